// File: rtl/counter_run_ctrl_pkg.sv
// Shared definitions for the display-counter run/step/clear sequencer.
package counter_run_ctrl_pkg;

  localparam int ST_W = 3;

  // Codes are exported on the state port, so the values are fixed.
  typedef enum logic [ST_W-1:0] {
    ST_IDLE  = 3'd0,
    ST_RUN   = 3'd1,
    ST_PAUSE = 3'd2,
    ST_STEP  = 3'd3,
    ST_CLEAR = 3'd4
  } state_t;

  // Registered outputs towards the counter datapath and the LEDs.
  typedef struct packed {
    logic cnt_en;
    logic cnt_clr;
    logic running;
    logic tick;
  } ctrl_out_t;

endpackage

// File: rtl/counter_run_ctrl_key_debounce.sv
// One push-button path: 2-flop synchronizer, level debouncer, and a
// registered one-cycle press pulse on the debounced 1->0 transition.
module key_debounce #(
  parameter int DEB_CYCLES = 500000
) (
  input  logic clk,
  input  logic rst,
  input  logic key_n,
  output logic press
);

  localparam int CNT_W = (DEB_CYCLES > 1) ? $clog2(DEB_CYCLES) : 1;
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(DEB_CYCLES - 1);

  logic             sync_p0;
  logic             sync_p1;
  logic             deb_lvl;
  logic             deb_lvl_d;
  logic [CNT_W-1:0] deb_cnt;

  // Bring the asynchronous key level into the clock domain; idle level is released.
  always_ff @(posedge clk) begin
    if (rst) begin
      sync_p0 <= 1'b1;
      sync_p1 <= 1'b1;
    end else begin
      sync_p0 <= key_n;
      sync_p1 <= sync_p0;
    end
  end

  // Accept a new level only after it has differed from the current one for DEB_CYCLES cycles.
  always_ff @(posedge clk) begin
    if (rst) begin
      deb_cnt <= '0;
      deb_lvl <= 1'b1;
    end else if (sync_p1 == deb_lvl) begin
      deb_cnt <= '0;
    end else if (deb_cnt == CNT_LAST) begin
      deb_lvl <= sync_p1;
      deb_cnt <= '0;
    end else begin
      deb_cnt <= deb_cnt + 1'b1;
    end
  end

  // Press is the debounced falling edge, one cycle wide; release is ignored.
  always_ff @(posedge clk) begin
    if (rst) begin
      deb_lvl_d <= 1'b1;
      press     <= 1'b0;
    end else begin
      deb_lvl_d <= deb_lvl;
      press     <= deb_lvl_d & ~deb_lvl;
    end
  end

endmodule

// File: rtl/counter_run_ctrl.sv
// Run/pause, single-step and clear sequencer for the board display counter.
// Debounces three active-low keys, runs the mode FSM and the run-mode
// prescaler, and drives registered enable/clear pulses to the counter.
module counter_run_ctrl
  import counter_run_ctrl_pkg::*;
#(
  parameter int DEB_CYCLES = 500000,
  parameter int TICK_DIV   = 50000000,
  parameter int DIV_W      = 26
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            key_run_n,
  input  logic            key_step_n,
  input  logic            key_clr_n,
  output logic            cnt_en,
  output logic            cnt_clr,
  output logic            running,
  output logic [ST_W-1:0] state,
  output logic            tick
);

  localparam logic [DIV_W-1:0] PRESC_LAST = DIV_W'(TICK_DIV - 1);

  logic             press_run;
  logic             press_step;
  logic             press_clr;
  state_t           state_q;
  state_t           state_d;
  logic [DIV_W-1:0] presc_q;
  logic [DIV_W-1:0] presc_d;
  logic             stay_run;
  ctrl_out_t        out_q;
  ctrl_out_t        out_d;

  key_debounce #(.DEB_CYCLES(DEB_CYCLES)) u_key_run (
    .clk   (clk),
    .rst   (rst),
    .key_n (key_run_n),
    .press (press_run)
  );

  key_debounce #(.DEB_CYCLES(DEB_CYCLES)) u_key_step (
    .clk   (clk),
    .rst   (rst),
    .key_n (key_step_n),
    .press (press_step)
  );

  key_debounce #(.DEB_CYCLES(DEB_CYCLES)) u_key_clr (
    .clk   (clk),
    .rst   (rst),
    .key_n (key_clr_n),
    .press (press_clr)
  );

  // State, prescaler and output registers.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= ST_IDLE;
      presc_q <= '0;
      out_q   <= '0;
    end else begin
      state_q <= state_d;
      presc_q <= presc_d;
      out_q   <= out_d;
    end
  end

  // Next mode from key presses (clr > run > step), prescaler update, and next outputs.
  always_comb begin
    state_d  = state_q;
    presc_d  = presc_q;
    stay_run = 1'b0;
    out_d    = '0;

    if (press_clr) begin
      state_d = ST_CLEAR;
    end else begin
      case (state_q)
        ST_IDLE, ST_PAUSE: begin
          if (press_run)       state_d = ST_RUN;
          else if (press_step) state_d = ST_STEP;
        end
        ST_RUN: begin
          if (press_run) state_d = ST_PAUSE;
        end
        ST_STEP:  state_d = ST_PAUSE;
        ST_CLEAR: state_d = ST_IDLE;
        default:  state_d = ST_IDLE;
      endcase
    end

    // The prescaler only advances across cycles spent entirely in RUN,
    // so a fresh entry always waits a full TICK_DIV cycles for its first tick.
    stay_run = (state_q == ST_RUN) && (state_d == ST_RUN);
    if ((state_d == ST_CLEAR) || ((state_d == ST_RUN) && (state_q != ST_RUN))) begin
      presc_d = '0;
    end else if (stay_run) begin
      presc_d = (presc_q == PRESC_LAST) ? '0 : presc_q + 1'b1;
    end

    out_d.tick    = stay_run && (presc_q == PRESC_LAST);
    out_d.cnt_en  = out_d.tick || (state_d == ST_STEP);
    out_d.cnt_clr = (state_d == ST_CLEAR);
    out_d.running = (state_d == ST_RUN);
  end

  assign state   = state_q;
  assign cnt_en  = out_q.cnt_en;
  assign cnt_clr = out_q.cnt_clr;
  assign running = out_q.running;
  assign tick    = out_q.tick;

endmodule

// File: tb/tb_counter_run_ctrl.sv
// Bench for counter_run_ctrl with short debounce and tick periods.
module tb_counter_run_ctrl;

  localparam int DEB  = 4;
  localparam int TDIV = 8;
  localparam int DW   = 4;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic       key_run_n = 1'b1;
  logic       key_step_n = 1'b1;
  logic       key_clr_n = 1'b1;
  logic       cnt_en;
  logic       cnt_clr;
  logic       running;
  logic [2:0] state;
  logic       tick;

  counter_run_ctrl #(.DEB_CYCLES(DEB), .TICK_DIV(TDIV), .DIV_W(DW)) dut (
    .clk        (clk),
    .rst        (rst),
    .key_run_n  (key_run_n),
    .key_step_n (key_step_n),
    .key_clr_n  (key_clr_n),
    .cnt_en     (cnt_en),
    .cnt_clr    (cnt_clr),
    .running    (running),
    .state      (state),
    .tick       (tick)
  );

  always #5 clk = ~clk;

  int compared   = 0;
  int mismatched = 0;
  int cyc        = 0;

  // Reference model. Modes: 0 idle, 1 run, 2 pause, 3 step, 4 clear.
  // Key bit order: [0] run, [1] step, [2] clr.
  int         m_mode = 0;
  int         m_run_cycles = 0;
  logic       m_tick = 1'b0;
  logic [2:0] m_deb = 3'b111;
  logic [2:0] m_fell = 3'b000;
  logic [2:0] m_press = 3'b000;
  logic [2:0] hist [0:DEB];   // hist[i] = key levels sampled i+1 edges ago

  task automatic model_edge();
    logic [2:0] keys;
    logic       flip;
    int         nm;
    keys = {key_clr_n, key_step_n, key_run_n};
    cyc++;
    if (rst) begin
      for (int i = 0; i <= DEB; i++) hist[i] = 3'b111;
      m_deb = 3'b111; m_fell = 3'b000; m_press = 3'b000;
      m_mode = 0; m_run_cycles = 0; m_tick = 1'b0;
    end else begin
      nm = m_mode;
      if (m_press[2]) nm = 4;
      else begin
        case (m_mode)
          0, 2: begin
            if (m_press[0]) nm = 1;
            else if (m_press[1]) nm = 3;
          end
          1: if (m_press[0]) nm = 2;
          3: nm = 2;
          default: nm = 0;
        endcase
      end
      if (nm == 1 && m_mode == 1) m_run_cycles++;
      else m_run_cycles = 0;
      m_tick = (nm == 1) && (m_mode == 1) && (m_run_cycles % TDIV == 0);
      m_mode = nm;
      // A key level is accepted once the DEB samples ending two edges ago all disagree with it.
      m_press = m_fell;
      for (int k = 0; k < 3; k++) begin
        flip = 1'b1;
        for (int i = 1; i <= DEB; i++) if (hist[i][k] == m_deb[k]) flip = 1'b0;
        m_fell[k] = 1'b0;
        if (flip) begin
          m_deb[k]  = ~m_deb[k];
          m_fell[k] = ~m_deb[k];
        end
      end
      for (int i = DEB; i >= 1; i--) hist[i] = hist[i-1];
      hist[0] = keys;
    end
  endtask

  function automatic logic [6:0] exp_vec();
    logic [2:0] st;
    st = 3'(m_mode);
    return {st, (m_mode == 1), (m_tick || (m_mode == 3)), (m_mode == 4), m_tick};
  endfunction

  function automatic logic [6:0] obs_vec();
    return {state, running, cnt_en, cnt_clr, tick};
  endfunction

  task automatic adv();
    @(posedge clk);
    model_edge();
    #1;
  endtask

  task automatic test_reset();
    rst = 1'b1; key_run_n = 1'b1; key_step_n = 1'b1; key_clr_n = 1'b1;
    repeat (3) adv();
    compared++;
    if (obs_vec() !== 7'd0) begin
      $display("FAIL reset_outputs: got %b want %b", obs_vec(), 7'd0); mismatched++;
    end
    rst = 1'b0;
    for (int k = 0; k < 100; k++) begin
      adv();
      compared++;
      if (obs_vec() !== 7'd0) begin
        $display("FAIL idle_keys_high cyc=%0d: got %b want %b", cyc, obs_vec(), 7'd0); mismatched++;
      end
    end
  endtask

  task automatic test_run_press();
    int first_run, first_en, ens;
    first_run = -1; first_en = -1; ens = 0;
    key_run_n = 1'b0;
    for (int k = 0; k < 40; k++) begin
      if (k == 20) key_run_n = 1'b1;
      adv();
      compared++;
      if (obs_vec() !== exp_vec()) begin
        $display("FAIL run_press cyc=%0d: got %b want %b", cyc, obs_vec(), exp_vec()); mismatched++;
      end
      if (state == 3'd1 && first_run < 0) first_run = k;
      if (cnt_en && first_en < 0) first_en = k;
      if (cnt_en) ens++;
    end
    compared++;
    if (first_run !== 7) begin
      $display("FAIL run_latency: got %0d want %0d", first_run, 7); mismatched++;
    end
    compared++;
    if (first_en !== 7 + TDIV) begin
      $display("FAIL first_tick: got %0d want %0d", first_en, 7 + TDIV); mismatched++;
    end
    compared++;
    if (ens !== 4) begin
      $display("FAIL tick_count: got %0d want %0d", ens, 4); mismatched++;
    end
  endtask

  task automatic test_pause_step();
    int ens, steps;
    ens = 0; steps = 0;
    key_run_n = 1'b0;
    for (int k = 0; k < 20; k++) begin
      if (k == 6) key_run_n = 1'b1;
      adv();
      compared++;
      if (obs_vec() !== exp_vec()) begin
        $display("FAIL pause cyc=%0d: got %b want %b", cyc, obs_vec(), exp_vec()); mismatched++;
      end
      if (k >= 10 && cnt_en) ens++;
    end
    compared++;
    if (state !== 3'd2 || ens !== 0) begin
      $display("FAIL pause_hold: got state %0d en %0d want state 2 en 0", state, ens); mismatched++;
    end
    ens = 0;
    key_step_n = 1'b0;
    for (int k = 0; k < 20; k++) begin
      if (k == 6) key_step_n = 1'b1;
      adv();
      compared++;
      if (obs_vec() !== exp_vec()) begin
        $display("FAIL step cyc=%0d: got %b want %b", cyc, obs_vec(), exp_vec()); mismatched++;
      end
      if (cnt_en) ens++;
      if (state == 3'd3) steps++;
    end
    compared++;
    if (ens !== 1 || steps !== 1 || state !== 3'd2) begin
      $display("FAIL single_step: got en %0d step %0d state %0d want 1 1 2", ens, steps, state); mismatched++;
    end
  endtask

  task automatic test_glitch();
    logic [2:0] st0;
    int ens;
    st0 = state; ens = 0;
    key_step_n = 1'b0;
    for (int k = 0; k < 15; k++) begin
      if (k == 3) key_step_n = 1'b1;
      adv();
      compared++;
      if (obs_vec() !== exp_vec()) begin
        $display("FAIL glitch cyc=%0d: got %b want %b", cyc, obs_vec(), exp_vec()); mismatched++;
      end
      if (cnt_en) ens++;
    end
    compared++;
    if (state !== st0 || ens !== 0) begin
      $display("FAIL glitch_ignored: got state %0d en %0d want state %0d en 0", state, ens, st0); mismatched++;
    end
  endtask

  task automatic test_clr_run_same();
    int clrs, clr_states;
    clrs = 0; clr_states = 0;
    key_run_n = 1'b0;
    for (int k = 0; k < 12; k++) begin
      if (k == 6) key_run_n = 1'b1;
      adv();
      compared++;
      if (obs_vec() !== exp_vec()) begin
        $display("FAIL rerun cyc=%0d: got %b want %b", cyc, obs_vec(), exp_vec()); mismatched++;
      end
    end
    compared++;
    if (state !== 3'd1) begin
      $display("FAIL rerun_state: got %0d want %0d", state, 1); mismatched++;
    end
    key_run_n = 1'b0; key_clr_n = 1'b0;
    for (int k = 0; k < 20; k++) begin
      if (k == 6) begin key_run_n = 1'b1; key_clr_n = 1'b1; end
      adv();
      compared++;
      if (obs_vec() !== exp_vec()) begin
        $display("FAIL clr_run cyc=%0d: got %b want %b", cyc, obs_vec(), exp_vec()); mismatched++;
      end
      if (cnt_clr) clrs++;
      if (state == 3'd4) clr_states++;
    end
    compared++;
    if (clrs !== 1 || clr_states !== 1 || state !== 3'd0) begin
      $display("FAIL clr_priority: got clr %0d clear_cycles %0d state %0d want 1 1 0", clrs, clr_states, state); mismatched++;
    end
  endtask

  task automatic test_reset_mid_run();
    int entry, first_en;
    entry = -1; first_en = -1;
    key_run_n = 1'b0;
    for (int k = 0; k < 11; k++) begin
      if (k == 6) key_run_n = 1'b1;
      adv();
      compared++;
      if (obs_vec() !== exp_vec()) begin
        $display("FAIL pre_reset cyc=%0d: got %b want %b", cyc, obs_vec(), exp_vec()); mismatched++;
      end
    end
    rst = 1'b1;
    adv();
    rst = 1'b0;
    compared++;
    if (obs_vec() !== 7'd0) begin
      $display("FAIL mid_run_reset: got %b want %b", obs_vec(), 7'd0); mismatched++;
    end
    key_run_n = 1'b0;
    for (int k = 0; k < 30; k++) begin
      if (k == 6) key_run_n = 1'b1;
      adv();
      compared++;
      if (obs_vec() !== exp_vec()) begin
        $display("FAIL post_reset cyc=%0d: got %b want %b", cyc, obs_vec(), exp_vec()); mismatched++;
      end
      if (state == 3'd1 && entry < 0) entry = k;
      if (cnt_en && first_en < 0) first_en = k;
    end
    compared++;
    if (entry < 0 || first_en - entry !== TDIV) begin
      $display("FAIL post_reset_tick: got entry %0d tick %0d want gap %0d", entry, first_en, TDIV); mismatched++;
    end
  endtask

  task automatic test_random();
    int         hold [3];
    logic [2:0] lvl;
    lvl = 3'b111;
    for (int i = 0; i < 3; i++) hold[i] = $urandom_range(1, 12);
    for (int k = 0; k < 3000; k++) begin
      for (int i = 0; i < 3; i++) begin
        hold[i]--;
        if (hold[i] <= 0) begin
          lvl[i]  = ~lvl[i];
          hold[i] = (i == 2) ? $urandom_range(1, 40) : $urandom_range(1, 12);
          if (i == 2 && lvl[i] == 1'b0) hold[i] = $urandom_range(1, 6);
        end
      end
      key_run_n  = lvl[0];
      key_step_n = lvl[1];
      key_clr_n  = lvl[2];
      rst = ($urandom_range(0, 399) == 0);
      adv();
      compared++;
      if (obs_vec() !== exp_vec()) begin
        $display("FAIL random cyc=%0d: got %b want %b", cyc, obs_vec(), exp_vec()); mismatched++;
      end
    end
    rst = 1'b0; key_run_n = 1'b1; key_step_n = 1'b1; key_clr_n = 1'b1;
  endtask

  initial begin
    test_reset();
    test_run_press();
    test_pause_step();
    test_glitch();
    test_clr_run_same();
    test_reset_mid_run();
    test_random();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
    $finish;
  end

endmodule
